// File: rtl/ram_ref_arb_pkg.sv
// Shared definitions for the DRAM access / CBR refresh arbiter.
package ram_ref_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACC_ROW  = 3'd1,
    ACC_COL  = 3'd2,
    REF_CAS  = 3'd3,
    REF_RAS  = 3'd4,
    REF_DONE = 3'd5,
    PRECHG   = 3'd6
  } state_e;

  localparam int PRECHG_CYC_DEF  = 2;
  localparam int REF_RAS_CYC_DEF = 3;

  // Down-counter load value: the phase lasts until the counter reads zero.
  function automatic logic [2:0] cyc_load(input int cyc);
    return 3'(cyc - 1);
  endfunction

endpackage

// File: rtl/ram_ref_arb_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ram_ref_arb.sv
// DRAM controller arbiter: CPU RAM accesses versus CAS-before-RAS refresh,
// with registered glitch-free strobes.
module ram_ref_arb
  import ram_ref_arb_pkg::*;
#(
  parameter int PRECHG_CYC  = PRECHG_CYC_DEF,
  parameter int REF_RAS_CYC = REF_RAS_CYC_DEF
) (
  input  logic FCLK,
  input  logic nRESin,
  input  logic RefReq,
  input  logic RefUrgent,
  input  logic BACT,
  input  logic RAMCS,
  output logic nRAS,
  output logic nCAS,
  output logic RASMux,
  output logic RAMReady,
  output logic RefAck,
  output logic RefMiss
);

  localparam logic [2:0] PRECHG_LOAD  = cyc_load(PRECHG_CYC);
  localparam logic [2:0] REF_RAS_LOAD = cyc_load(REF_RAS_CYC);

  logic   ref_req_s, ref_urg_s, ref_rise;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic   ref_req_dly_q, ref_req_dly_d;
  logic   ref_pend_q, ref_pend_d;
  logic   ref_miss_q, ref_miss_d;
  logic   nras_q, nras_d;
  logic   ncas_q, ncas_d;
  logic   rasmux_q, rasmux_d;
  logic   ready_q, ready_d;
  logic   ack_q, ack_d;

  sync2 u_sync_req (.clk(FCLK), .rst_n(nRESin), .d(RefReq),    .q(ref_req_s));
  sync2 u_sync_urg (.clk(FCLK), .rst_n(nRESin), .d(RefUrgent), .q(ref_urg_s));

  assign ref_rise = ref_req_s & ~ref_req_dly_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ref_pend_q && ref_urg_s)  state_d = REF_CAS;
        else if (BACT && RAMCS)       state_d = ACC_ROW;
        else if (ref_pend_q)          state_d = REF_CAS;
      end
      ACC_ROW:  state_d = BACT ? ACC_COL : PRECHG;
      ACC_COL:  if (!BACT) state_d = PRECHG;
      REF_CAS:  state_d = REF_RAS;
      REF_RAS: begin
        if (cnt_q == 3'd0) state_d = REF_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      REF_DONE: state_d = PRECHG;
      PRECHG: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default:  state_d = IDLE;
    endcase

    if (state_d == REF_RAS && state_q != REF_RAS) cnt_d = REF_RAS_LOAD;
    if (state_d == PRECHG  && state_q != PRECHG)  cnt_d = PRECHG_LOAD;
  end

  // A new request edge beats the clear on REF_DONE entry so it is never lost.
  always_comb begin
    ref_req_dly_d = ref_req_s;
    ref_pend_d    = ref_rise |
                    (ref_pend_q & ~(state_d == REF_DONE && state_q != REF_DONE));
    ref_miss_d    = ref_miss_q | (ref_rise & ref_pend_q);
  end

  // Outputs decoded from the next state so they flop together with it.
  always_comb begin
    nras_d   = !(state_d == ACC_ROW || state_d == ACC_COL || state_d == REF_RAS);
    ncas_d   = !(state_d == ACC_COL || state_d == REF_CAS || state_d == REF_RAS);
    rasmux_d = (state_d == ACC_COL);
    ready_d  = (state_d == ACC_COL);
    ack_d    = (state_d == REF_DONE);
  end

  always_ff @(posedge FCLK or negedge nRESin) begin
    if (!nRESin) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      ref_req_dly_q <= 1'b0;
      ref_pend_q    <= 1'b0;
      ref_miss_q    <= 1'b0;
      nras_q        <= 1'b1;
      ncas_q        <= 1'b1;
      rasmux_q      <= 1'b0;
      ready_q       <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ref_req_dly_q <= ref_req_dly_d;
      ref_pend_q    <= ref_pend_d;
      ref_miss_q    <= ref_miss_d;
      nras_q        <= nras_d;
      ncas_q        <= ncas_d;
      rasmux_q      <= rasmux_d;
      ready_q       <= ready_d;
      ack_q         <= ack_d;
    end
  end

  assign nRAS     = nras_q;
  assign nCAS     = ncas_q;
  assign RASMux   = rasmux_q;
  assign RAMReady = ready_q;
  assign RefAck   = ack_q;
  assign RefMiss  = ref_miss_q;

endmodule
